// File: rtl/imm_ext_ctrl_pkg.sv
// Shared constants for the immediate/displacement extension sequencer:
// beat formats, prefix FSM state encodings and default field widths.
package imm_ext_ctrl_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_IMM_W  = 18;
    localparam int DEF_MD_W   = 22;

    typedef logic [1:0] fmt_t;

    localparam fmt_t FMT_NONE   = 2'd0;
    localparam fmt_t FMT_IMM18  = 2'd1;
    localparam fmt_t FMT_MD22   = 2'd2;
    localparam fmt_t FMT_PREFIX = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

endpackage

// File: rtl/imm_ext_ctrl_sext.sv
// imm_sext: pure combinational sign extension of an IN_W-bit field to OUT_W bits.
module imm_sext
    import imm_ext_ctrl_pkg::*;
#(
    parameter int IN_W  = DEF_IMM_W,
    parameter int OUT_W = DEF_DATA_W
) (
    input  logic [IN_W-1:0]  field,
    output logic [OUT_W-1:0] value
);

    assign value = {{(OUT_W-IN_W){field[IN_W-1]}}, field};

endmodule

// File: rtl/imm_ext_ctrl.sv
// imm_ext_ctrl: decode-stage immediate/displacement extender with one registered output stage.
// Define IMMX_PREFIX_EN to enable PREFIX merging (IDLE/HELD FSM); otherwise fmt 3 flags out_err.
module imm_ext_ctrl
    import imm_ext_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMM_W  = DEF_IMM_W,
    parameter int MD_W   = DEF_MD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_pfx,
    output logic              out_err
);

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] md_ext;
    logic              accept;
    logic [DATA_W-1:0] nxt_data;
    logic              nxt_pfx;
    logic              nxt_err;
    logic              nxt_beat;
    logic              instr_unused;

    assign instr_unused = ^in_instr[31:MD_W];

    imm_sext #(.IN_W(IMM_W), .OUT_W(DATA_W)) u_sext_imm (
        .field (in_instr[IMM_W-1:0]),
        .value (imm_ext)
    );

    imm_sext #(.IN_W(MD_W), .OUT_W(DATA_W)) u_sext_md (
        .field (in_instr[MD_W-1:0]),
        .value (md_ext)
    );

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

`ifdef IMMX_PREFIX_EN
    logic [0:0]      state;
    logic [0:0]      nxt_state;
    logic [MD_W-1:0] pfx_reg;
    logic [MD_W-1:0] nxt_pfx_reg;

    always_comb begin
        nxt_data    = '0;
        nxt_pfx     = 1'b0;
        nxt_err     = 1'b0;
        nxt_beat    = 1'b1;
        nxt_state   = state;
        nxt_pfx_reg = pfx_reg;
        case (in_fmt)
            FMT_IMM18: begin
                if (state == ST_HELD) begin
                    nxt_data  = {pfx_reg[DATA_W-IMM_W-1:0], in_instr[IMM_W-1:0]};
                    nxt_pfx   = 1'b1;
                    nxt_state = ST_IDLE;
                end else begin
                    nxt_data = imm_ext;
                end
            end
            FMT_MD22: begin
                if (state == ST_HELD) begin
                    nxt_data  = {pfx_reg[DATA_W-MD_W-1:0], in_instr[MD_W-1:0]};
                    nxt_pfx   = 1'b1;
                    nxt_state = ST_IDLE;
                end else begin
                    nxt_data = md_ext;
                end
            end
            FMT_PREFIX: begin
                // a prefix is absorbed here and never occupies the output stage
                nxt_beat    = 1'b0;
                nxt_pfx_reg = in_instr[MD_W-1:0];
                nxt_state   = ST_HELD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            pfx_reg <= '0;
        end else if (flush) begin
            state   <= ST_IDLE;
            pfx_reg <= '0;
        end else if (accept) begin
            state   <= nxt_state;
            pfx_reg <= nxt_pfx_reg;
        end
    end
`else
    always_comb begin
        nxt_data = '0;
        nxt_pfx  = 1'b0;
        nxt_err  = 1'b0;
        nxt_beat = 1'b1;
        case (in_fmt)
            FMT_IMM18:  nxt_data = imm_ext;
            FMT_MD22:   nxt_data = md_ext;
            FMT_PREFIX: nxt_err  = 1'b1;
            default: ;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pfx   <= 1'b0;
            out_err   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= nxt_beat;
            if (nxt_beat) begin
                out_data <= nxt_data;
                out_pfx  <= nxt_pfx;
                out_err  <= nxt_err;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Randomized self-checking bench for imm_ext_ctrl against a queue-based operand model.
module tb_imm_ext_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_pfx;
    logic        out_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        bit          pfx;
        bit          err;
    } beat_t;

    beat_t       exp_q[$];
    bit          held        = 1'b0;
    longint      held_pfx    = 0;
    bit          after_reset = 1'b0;

    imm_ext_ctrl #(.DATA_W(32), .IMM_W(18), .MD_W(22)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_pfx   (out_pfx),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check_eq("out_valid", {31'd0, out_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
        if (exp_q.size() != 0) begin
            check_eq("out_data", out_data, exp_q[0].data);
            check_eq("out_pfx", {31'd0, out_pfx}, {31'd0, exp_q[0].pfx});
            check_eq("out_err", {31'd0, out_err}, {31'd0, exp_q[0].err});
        end else if (after_reset) begin
            check_eq("rst_data", out_data, 32'd0);
            check_eq("rst_pfx", {31'd0, out_pfx}, 32'd0);
            check_eq("rst_err", {31'd0, out_err}, 32'd0);
        end
        after_reset = 1'b0;
    endtask

    // Operand arithmetic straight from the format rules.
    function automatic void model_accept(input logic [1:0] f, input logic [31:0] ins);
        longint imm, md, raw_imm, raw_md;
        beat_t  b;
        raw_imm = longint'(ins) % (64'd1 << 18);
        raw_md  = longint'(ins) % (64'd1 << 22);
        imm = (raw_imm >= (64'd1 << 17)) ? raw_imm - (64'd1 << 18) : raw_imm;
        md  = (raw_md  >= (64'd1 << 21)) ? raw_md  - (64'd1 << 22) : raw_md;
        b.data = '0;
        b.pfx  = 1'b0;
        b.err  = 1'b0;
        case (f)
            2'd1: begin
                if (held) begin
                    b.data = 32'((held_pfx % (64'd1 << 14)) * (64'd1 << 18) + raw_imm);
                    b.pfx  = 1'b1;
                    held   = 1'b0;
                end else begin
                    b.data = 32'(imm);
                end
                exp_q.push_back(b);
            end
            2'd2: begin
                if (held) begin
                    b.data = 32'((held_pfx % (64'd1 << 10)) * (64'd1 << 22) + raw_md);
                    b.pfx  = 1'b1;
                    held   = 1'b0;
                end else begin
                    b.data = 32'(md);
                end
                exp_q.push_back(b);
            end
            2'd3: begin
`ifdef IMMX_PREFIX_EN
                held     = 1'b1;
                held_pfx = raw_md;
`else
                b.err = 1'b1;
                exp_q.push_back(b);
`endif
            end
            default: exp_q.push_back(b);
        endcase
    endfunction

    task automatic step(input bit v, input logic [1:0] f, input logic [31:0] ins,
                        input bit ordy, input bit fl, input bit rst);
        bit exp_ready;
        compare_outputs();
        in_valid  = v;
        in_fmt    = f;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        exp_ready = (exp_q.size() == 0) || ordy;
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        if (rst || fl) begin
            exp_q.delete();
            held     = 1'b0;
            held_pfx = 0;
            if (rst) after_reset = 1'b1;
        end else begin
            if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
            if (v && exp_ready) model_accept(f, ins);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_instr();
        logic [31:0] corners [6];
        corners = '{32'h0003FFFF, 32'h0001FFFF, 32'h00020000, 32'h00200000, 32'h001FFFFF, 32'h0};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = 2'd0;
        in_instr  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        after_reset = 1'b1;

        // back-to-back IMM18 at full throughput
        step(1'b1, 2'd1, 32'h0003FFFF, 1'b1, 1'b0, 1'b0);
        check_eq("imm_neg", out_data, 32'hFFFFFFFF);
        step(1'b1, 2'd1, 32'h0001FFFF, 1'b1, 1'b0, 1'b0);
        check_eq("imm_pos", out_data, 32'h0001FFFF);

        // MD22 stalled for three cycles with a beat waiting upstream
        step(1'b1, 2'd2, 32'h00200000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_eq("md_hold", out_data, 32'hFFE00000);
            step(1'b1, 2'd1, 32'h00000005, 1'b0, 1'b0, 1'b0);
            check_eq("stall_rdy", {31'd0, in_ready}, 32'd0);
        end
        check_eq("md_still", out_data, 32'hFFE00000);
        step(1'b1, 2'd1, 32'h00000005, 1'b1, 1'b0, 1'b0);
        check_eq("after_stall", out_data, 32'h00000005);

`ifdef IMMX_PREFIX_EN
        step(1'b1, 2'd3, 32'h0000ABCD, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd1, 32'h00000001, 1'b1, 1'b0, 1'b0);
        check_eq("pfx_imm", out_data, 32'hAF340001);
        check_eq("pfx_imm_flag", {31'd0, out_pfx}, 32'd1);

        step(1'b1, 2'd3, 32'h000003FF, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 32'h12345678, 1'b1, 1'b0, 1'b0);
        check_eq("held_none", out_data, 32'h0);
        step(1'b1, 2'd2, 32'h00000005, 1'b1, 1'b0, 1'b0);
        check_eq("pfx_md", out_data, 32'hFFC00005);
        check_eq("pfx_md_flag", {31'd0, out_pfx}, 32'd1);

        step(1'b1, 2'd3, 32'h003FFFFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 2'd1, 32'h00000010, 1'b1, 1'b0, 1'b0);
        check_eq("flush_imm", out_data, 32'h00000010);
        check_eq("flush_pfx", {31'd0, out_pfx}, 32'd0);
`else
        step(1'b1, 2'd3, 32'h0000ABCD, 1'b1, 1'b0, 1'b0);
        check_eq("bad_data", out_data, 32'h0);
        check_eq("bad_err", {31'd0, out_err}, 32'd1);
        step(1'b1, 2'd1, 32'h00000010, 1'b1, 1'b0, 1'b0);
        check_eq("next_err", {31'd0, out_err}, 32'd0);
        check_eq("next_data", out_data, 32'h00000010);
`endif

        // flush overriding a same-cycle accept
        step(1'b1, 2'd1, 32'h00000077, 1'b1, 1'b1, 1'b0);
        check_eq("flush_drop", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)),
                 pick_instr(),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 79) == 0);
        end
        step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        compare_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
